// File: rtl/accum_table_ctrl.sv
// accum_table_ctrl
//   Sequencer for the accumulator table. It runs one job at a time:
//   - clear: pulse the per-column table reset for the selected columns
//   - write: issue a block of accumulate enables/addresses. Column c is
//     delayed by c cycles so it lines up with the systolic array's skewed
//     output.
//   - read: issue a block of reads on all columns at once, with a
//     data-valid strobe one cycle later.
//
// Handshake: a job is accepted on a rising clock edge where its *_start is
//   high and ready is high (ready is high only in IDLE). Job parameters are
//   captured on that same edge. When several starts arrive together, clr
//   wins over wr, and wr wins over rd. The losing starts are dropped, and
//   starts seen while busy are ignored. ready stays low until the cycle
//   after the one-cycle done pulse.
//
// Ports
//   clk, reset_n            clock (rising edge), async active-low reset
//   clr_start, clr_mask     clear request and the columns to clear
//   wr_start/base/rows      accumulate request: first table row, row count
//   rd_start/base/rows      read request: first table row, row count
//   ready, done             idle indication, job-complete pulse
//   tbl_reset               per-column clear to the table
//   tbl_wr_en, tbl_wr_addr  per-column write enable / address (col c at
//                           [c*ADDR_W +: ADDR_W])
//   tbl_rd_en, tbl_rd_addr  per-column read enable / address
//   rd_valid                table read data valid
//   dbg_state               current sequencer state
module accum_table_ctrl #(
  parameter int SYS_ARR_COLS = 16,
  parameter int MAX_OUT_ROWS = 128,
  parameter int MAX_OUT_COLS = 128,
  localparam int NUM_ACCUM_ROWS = MAX_OUT_ROWS * (MAX_OUT_COLS / SYS_ARR_COLS),
  localparam int ADDR_W = $clog2(NUM_ACCUM_ROWS),
  localparam int CNT_W = $clog2(MAX_OUT_ROWS) + 1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           clr_start,
  input  logic [SYS_ARR_COLS-1:0]        clr_mask,
  input  logic                           wr_start,
  input  logic [ADDR_W-1:0]              wr_base,
  input  logic [CNT_W-1:0]               wr_rows,
  input  logic                           rd_start,
  input  logic [ADDR_W-1:0]              rd_base,
  input  logic [CNT_W-1:0]               rd_rows,
  output logic                           ready,
  output logic                           done,
  output logic [SYS_ARR_COLS-1:0]        tbl_reset,
  output logic [SYS_ARR_COLS-1:0]        tbl_wr_en,
  output logic [ADDR_W*SYS_ARR_COLS-1:0] tbl_wr_addr,
  output logic [SYS_ARR_COLS-1:0]        tbl_rd_en,
  output logic [ADDR_W*SYS_ARR_COLS-1:0] tbl_rd_addr,
  output logic                           rd_valid,
  output logic [2:0]                     dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_WRITE = 3'd2,
    S_FLUSH = 3'd3,
    S_READ  = 3'd4
  } state_t;

  // FLUSH counts down to 0 and raises done on its last cycle. That last
  // cycle is also the cycle of the last column's final write.
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(SYS_ARR_COLS - 2);
  localparam logic [CNT_W-1:0] ROWS_MAX   = CNT_W'(MAX_OUT_ROWS);

  state_t                    r_state, w_state_nxt;
  logic [CNT_W-1:0]          r_cnt, w_cnt_nxt;
  logic [SYS_ARR_COLS-1:0]   r_tbl_reset, w_tbl_reset_nxt;
  logic [SYS_ARR_COLS-1:0]   r_wr_en;
  logic [ADDR_W-1:0]         r_wr_addr [SYS_ARR_COLS];
  logic                      w_wr_en0_nxt;
  logic [ADDR_W-1:0]         w_wr_addr0_nxt;
  logic                      r_rd_en, w_rd_en_nxt;
  logic [ADDR_W-1:0]         r_rd_addr, w_rd_addr_nxt;
  logic                      r_rd_valid;
  logic                      w_done;
  logic [CNT_W-1:0]          w_wr_rows_c, w_rd_rows_c;

  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    if (a == ADDR_W'(NUM_ACCUM_ROWS - 1)) return '0;
    return a + 1'b1;
  endfunction

  assign w_wr_rows_c = (wr_rows > ROWS_MAX) ? ROWS_MAX : wr_rows;
  assign w_rd_rows_c = (rd_rows > ROWS_MAX) ? ROWS_MAX : rd_rows;

  // r_cnt meaning per state:
  //   CLEAR: cycles left before done
  //   WRITE: col-0 rows still to issue, including the current one
  //   FLUSH: cycles left before done
  //   READ : rows still to issue, including the one currently on the bus
  // Address registers keep their value unless a new enable is being issued,
  // so addresses never toggle while their enable is low.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_tbl_reset_nxt = '0;
    w_wr_en0_nxt    = 1'b0;
    w_wr_addr0_nxt  = r_wr_addr[0];
    w_rd_en_nxt     = 1'b0;
    w_rd_addr_nxt   = r_rd_addr;
    w_done          = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (clr_start) begin
          w_state_nxt     = S_CLEAR;
          w_cnt_nxt       = CNT_W'(1);
          w_tbl_reset_nxt = clr_mask;
        end else if (wr_start) begin
          if (w_wr_rows_c == '0) begin
            w_state_nxt = S_FLUSH;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt    = S_WRITE;
            w_cnt_nxt      = w_wr_rows_c;
            w_wr_en0_nxt   = 1'b1;
            w_wr_addr0_nxt = wr_base;
          end
        end else if (rd_start) begin
          w_state_nxt = S_READ;
          w_cnt_nxt   = w_rd_rows_c;
          if (w_rd_rows_c != '0) begin
            w_rd_en_nxt   = 1'b1;
            w_rd_addr_nxt = rd_base;
          end
        end
      end
      S_CLEAR, S_FLUSH: begin
        if (r_cnt == '0) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_WRITE: begin
        if (r_cnt > CNT_W'(1)) begin
          w_cnt_nxt      = r_cnt - 1'b1;
          w_wr_en0_nxt   = 1'b1;
          w_wr_addr0_nxt = addr_inc(r_wr_addr[0]);
        end else begin
          w_state_nxt = S_FLUSH;
          w_cnt_nxt   = FLUSH_LAST;
        end
      end
      S_READ: begin
        if (r_cnt == '0) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
          if (r_cnt > CNT_W'(1)) begin
            w_rd_en_nxt   = 1'b1;
            w_rd_addr_nxt = addr_inc(r_rd_addr);
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_tbl_reset <= '0;
      r_wr_en     <= '0;
      for (int c = 0; c < SYS_ARR_COLS; c++) r_wr_addr[c] <= '0;
      r_rd_en     <= 1'b0;
      r_rd_addr   <= '0;
      r_rd_valid  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_tbl_reset  <= w_tbl_reset_nxt;
      // Skew chain: column c repeats column c-1 one cycle later. A stage
      // address only loads alongside an enable.
      r_wr_en      <= {r_wr_en[SYS_ARR_COLS-2:0], w_wr_en0_nxt};
      r_wr_addr[0] <= w_wr_addr0_nxt;
      for (int c = 1; c < SYS_ARR_COLS; c++) begin
        if (r_wr_en[c-1]) r_wr_addr[c] <= r_wr_addr[c-1];
      end
      r_rd_en      <= w_rd_en_nxt;
      r_rd_addr    <= w_rd_addr_nxt;
      r_rd_valid   <= r_rd_en;
    end
  end

  always_comb begin
    tbl_wr_addr = '0;
    for (int c = 0; c < SYS_ARR_COLS; c++) begin
      tbl_wr_addr[c*ADDR_W +: ADDR_W] = r_wr_addr[c];
    end
  end

  assign ready       = (r_state == S_IDLE);
  assign done        = w_done;
  assign tbl_reset   = r_tbl_reset;
  assign tbl_wr_en   = r_wr_en;
  assign tbl_rd_en   = {SYS_ARR_COLS{r_rd_en}};
  assign tbl_rd_addr = {SYS_ARR_COLS{r_rd_addr}};
  assign rd_valid    = r_rd_valid;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_accum_table_ctrl.sv
// Bench for accum_table_ctrl.
//
// A job-level reference model tracks the accepted job and how many cycles
// have passed since acceptance. A compare process derives every expected
// output each cycle from the job's timing rules. Directed sequences add
// hand-computed literal checks, and a random phase follows them.
module tb_accum_table_ctrl;
  localparam int COLS = 16;
  localparam int MAXR = 128;
  localparam int N    = 1024;
  localparam int AW   = 10;
  localparam int CW   = 8;
  localparam int VW   = AW * COLS;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  logic            clr_start, wr_start, rd_start;
  logic [COLS-1:0] clr_mask;
  logic [AW-1:0]   wr_base, rd_base;
  logic [CW-1:0]   wr_rows, rd_rows;
  logic            ready, done, rd_valid;
  logic [COLS-1:0] tbl_reset, tbl_wr_en, tbl_rd_en;
  logic [VW-1:0]   tbl_wr_addr, tbl_rd_addr;
  logic [2:0]      dbg_state;

  accum_table_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .clr_start(clr_start), .clr_mask(clr_mask),
    .wr_start(wr_start), .wr_base(wr_base), .wr_rows(wr_rows),
    .rd_start(rd_start), .rd_base(rd_base), .rd_rows(rd_rows),
    .ready(ready), .done(done), .tbl_reset(tbl_reset),
    .tbl_wr_en(tbl_wr_en), .tbl_wr_addr(tbl_wr_addr),
    .tbl_rd_en(tbl_rd_en), .tbl_rd_addr(tbl_rd_addr),
    .rd_valid(rd_valid), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk_i(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_w(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum int {K_IDLE, K_CLR, K_WR, K_RD} kind_t;
  kind_t           m_kind = K_IDLE;
  int              m_t = 0, m_end = 0, m_rows = 0, m_base = 0;
  logic [COLS-1:0] m_mask = '0;

  function automatic int clamp_rows(input int r);
    return (r > MAXR) ? MAXR : r;
  endfunction

  // m_t is the cycle number within the job; acceptance is cycle 0.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_kind <= K_IDLE;
    end else if (m_kind == K_IDLE) begin
      m_t <= 1;
      if (clr_start) begin
        m_kind <= K_CLR; m_mask <= clr_mask; m_end <= 2;
      end else if (wr_start) begin
        m_kind <= K_WR; m_base <= int'(wr_base); m_rows <= clamp_rows(int'(wr_rows));
        m_end  <= (clamp_rows(int'(wr_rows)) == 0) ? 1 : clamp_rows(int'(wr_rows)) + COLS - 1;
      end else if (rd_start) begin
        m_kind <= K_RD; m_base <= int'(rd_base); m_rows <= clamp_rows(int'(rd_rows));
        m_end  <= clamp_rows(int'(rd_rows)) + 1;
      end
    end else if (m_t == m_end) begin
      m_kind <= K_IDLE;
    end else begin
      m_t <= m_t + 1;
    end
  end

  // ---------------- compare process ----------------
  bit              cmp_on = 0;
  bit              have_prev = 0;
  logic [VW-1:0]   prev_wr_addr, prev_rd_addr;
  logic [COLS-1:0] e_rst, e_wr_en, e_rd_en;
  logic [VW-1:0]   e_wr_addr, wr_amask, e_rd_addr, hold_mask;
  logic [AW-1:0]   ra;
  logic            e_ready, e_done, e_rd_valid, rd_on;
  int              k;

  always @(negedge clk) begin
    if (cmp_on) begin
      e_ready = (m_kind == K_IDLE);
      e_done  = (m_kind != K_IDLE) && (m_t == m_end);
      e_rst   = (m_kind == K_CLR && m_t == 1) ? m_mask : '0;
      e_wr_en = '0; e_wr_addr = '0; wr_amask = '0;
      for (int c = 0; c < COLS; c++) begin
        k = m_t - 1 - c;
        if (m_kind == K_WR && k >= 0 && k < m_rows) begin
          e_wr_en[c] = 1'b1;
          e_wr_addr[c*AW +: AW] = AW'((m_base + k) % N);
          wr_amask[c*AW +: AW]  = '1;
        end
      end
      k = m_t - 1;
      rd_on      = (m_kind == K_RD) && k >= 0 && k < m_rows;
      ra         = AW'((m_base + k) % N);
      e_rd_en    = rd_on ? '1 : '0;
      e_rd_addr  = rd_on ? {COLS{ra}} : '0;
      e_rd_valid = (m_kind == K_RD) && m_t >= 2 && m_t <= m_rows + 1;

      chk_i("ready", int'(ready), int'(e_ready));
      chk_i("done", int'(done), int'(e_done));
      chk_i("tbl_reset", int'(tbl_reset), int'(e_rst));
      chk_i("tbl_wr_en", int'(tbl_wr_en), int'(e_wr_en));
      chk_w("tbl_wr_addr", tbl_wr_addr & wr_amask, e_wr_addr);
      chk_i("tbl_rd_en", int'(tbl_rd_en), int'(e_rd_en));
      chk_w("tbl_rd_addr", rd_on ? tbl_rd_addr : '0, e_rd_addr);
      chk_i("rd_valid", int'(rd_valid), int'(e_rd_valid));

      // Addresses behind a low enable must not move from cycle to cycle.
      if (have_prev && reset_n) begin
        hold_mask = '0;
        for (int c = 0; c < COLS; c++) if (!e_wr_en[c]) hold_mask[c*AW +: AW] = '1;
        chk_w("wr_addr_hold", tbl_wr_addr & hold_mask, prev_wr_addr & hold_mask);
        if (!rd_on) chk_w("rd_addr_hold", tbl_rd_addr, prev_rd_addr);
      end
      prev_wr_addr = tbl_wr_addr;
      prev_rd_addr = tbl_rd_addr;
      have_prev    = reset_n;
    end
  end

  // ---------------- driver tasks ----------------
  int cyc = 0;

  task automatic scramble_params();
    clr_mask = COLS'($urandom_range(0, 65535));
    wr_base  = AW'($urandom_range(0, N - 1));
    rd_base  = AW'($urandom_range(0, N - 1));
    wr_rows  = CW'($urandom_range(0, 255));
    rd_rows  = CW'($urandom_range(0, 255));
  endtask

  // Raises the requested starts for one cycle (cycle 0). It returns 2 time
  // units into cycle 1, with cyc = 0.
  task automatic launch(input logic c, input logic w, input logic r,
                        input logic [COLS-1:0] m, input logic [AW-1:0] wb,
                        input logic [CW-1:0] wn, input logic [AW-1:0] rb,
                        input logic [CW-1:0] rn);
    @(posedge clk); #2;
    clr_start = c; wr_start = w; rd_start = r;
    clr_mask = m; wr_base = wb; wr_rows = wn; rd_base = rb; rd_rows = rn;
    @(posedge clk); #2;
    clr_start = 0; wr_start = 0; rd_start = 0;
    scramble_params();
    cyc = 0;
  endtask

  task automatic at_cycle(input int t);
    while (cyc < t) begin
      @(negedge clk);
      cyc++;
    end
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    bit seen = 0;
    while (n < 400 && !seen) begin
      @(negedge clk);
      seen = ready;
      n++;
    end
    chk_i("wait_idle", int'(seen), 1);
  endtask

  function automatic logic [CW-1:0] rand_rows();
    int r = $urandom_range(0, 9);
    if (r == 0) return '0;
    if (r == 1) return CW'($urandom_range(129, 255));
    if (r < 6)  return CW'($urandom_range(1, 4));
    return CW'($urandom_range(5, 40));
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    clr_start = 0; wr_start = 0; rd_start = 0;
    clr_mask = '0; wr_base = '0; wr_rows = '0; rd_base = '0; rd_rows = '0;
    #3 reset_n = 0;
    cmp_on = 1;
    repeat (3) @(posedge clk);
    #2 reset_n = 1;

    // idle after reset
    repeat (20) @(negedge clk);
    #1;
    chk_i("idle_ready", int'(ready), 1);
    chk_i("idle_wr_en", int'(tbl_wr_en), 0);
    chk_i("idle_done", int'(done), 0);

    // clear
    launch(1, 0, 0, 16'h00F0, 0, 0, 0, 0);
    at_cycle(1);
    chk_i("clr_reset_c1", int'(tbl_reset), 'h00F0);
    chk_i("clr_ready_c1", int'(ready), 0);
    at_cycle(2);
    chk_i("clr_done_c2", int'(done), 1);
    chk_i("clr_reset_c2", int'(tbl_reset), 0);
    at_cycle(3);
    chk_i("clr_ready_c3", int'(ready), 1);
    wait_idle();

    // write base=5 rows=3
    launch(0, 1, 0, 0, 10'd5, 8'd3, 0, 0);
    at_cycle(1);
    chk_i("wr_en_c1", int'(tbl_wr_en), 'h0001);
    chk_i("wr_col0_addr_c1", int'(tbl_wr_addr[0 +: AW]), 5);
    at_cycle(3);
    chk_i("wr_en_c3", int'(tbl_wr_en), 'h0007);
    chk_i("wr_col0_addr_c3", int'(tbl_wr_addr[0 +: AW]), 7);
    at_cycle(16);
    chk_i("wr_en_c16", int'(tbl_wr_en), 'hE000);
    chk_i("wr_col15_addr_c16", int'(tbl_wr_addr[15*AW +: AW]), 5);
    at_cycle(18);
    chk_i("wr_en_c18", int'(tbl_wr_en), 'h8000);
    chk_i("wr_col15_addr_c18", int'(tbl_wr_addr[15*AW +: AW]), 7);
    chk_i("wr_done_c18", int'(done), 1);
    at_cycle(19);
    chk_i("wr_ready_c19", int'(ready), 1);
    wait_idle();

    // read base=1022 rows=4 (wraps)
    launch(0, 0, 1, 0, 0, 0, 10'd1022, 8'd4);
    at_cycle(1);
    chk_i("rd_en_c1", int'(tbl_rd_en), 'hFFFF);
    chk_i("rd_addr_c1", int'(tbl_rd_addr[0 +: AW]), 1022);
    chk_i("rd_valid_c1", int'(rd_valid), 0);
    at_cycle(3);
    chk_i("rd_addr_c3", int'(tbl_rd_addr[7*AW +: AW]), 0);
    at_cycle(4);
    chk_i("rd_addr_c4", int'(tbl_rd_addr[15*AW +: AW]), 1);
    at_cycle(5);
    chk_i("rd_en_c5", int'(tbl_rd_en), 0);
    chk_i("rd_valid_c5", int'(rd_valid), 1);
    chk_i("rd_done_c5", int'(done), 1);
    wait_idle();

    // simultaneous starts: clear wins; starts while busy are dropped
    launch(1, 1, 1, 16'hA5A5, 10'd3, 8'd5, 10'd7, 8'd5);
    at_cycle(1);
    chk_i("prio_reset_c1", int'(tbl_reset), 'hA5A5);
    chk_i("prio_wr_en_c1", int'(tbl_wr_en), 0);
    wr_start = 1; rd_start = 1;
    @(posedge clk); #2;
    wr_start = 0; rd_start = 0;
    at_cycle(2);
    chk_i("prio_done_c2", int'(done), 1);
    at_cycle(3);
    chk_i("prio_ready_c3", int'(ready), 1);
    chk_i("prio_no_wr_c3", int'(tbl_wr_en), 0);
    chk_i("prio_no_rd_c3", int'(tbl_rd_en), 0);
    wait_idle();

    // zero-row jobs
    launch(0, 1, 0, 0, 10'd9, 8'd0, 0, 0);
    at_cycle(1);
    chk_i("wr0_done_c1", int'(done), 1);
    chk_i("wr0_en_c1", int'(tbl_wr_en), 0);
    at_cycle(2);
    chk_i("wr0_ready_c2", int'(ready), 1);
    launch(0, 0, 1, 0, 0, 0, 10'd9, 8'd0);
    at_cycle(1);
    chk_i("rd0_done_c1", int'(done), 1);
    chk_i("rd0_en_c1", int'(tbl_rd_en), 0);
    wait_idle();

    // clamped write: 200 rows -> 128
    launch(0, 1, 0, 0, 10'd1000, 8'd200, 0, 0);
    at_cycle(128);
    chk_i("clamp_col0_addr_c128", int'(tbl_wr_addr[0 +: AW]), 103);
    chk_i("clamp_col0_en_c128", int'(tbl_wr_en[0]), 1);
    at_cycle(129);
    chk_i("clamp_col0_en_c129", int'(tbl_wr_en[0]), 0);
    at_cycle(143);
    chk_i("clamp_done_c143", int'(done), 1);
    chk_i("clamp_col15_addr_c143", int'(tbl_wr_addr[15*AW +: AW]), 103);
    wait_idle();

    // reset in the middle of a write
    launch(0, 1, 0, 0, 10'd0, 8'd10, 0, 0);
    at_cycle(8);
    chk_i("abort_wr_en_c8", int'(tbl_wr_en), 'h00FF);
    reset_n = 0;
    #1;
    chk_i("abort_wr_en", int'(tbl_wr_en), 0);
    chk_i("abort_ready", int'(ready), 1);
    chk_i("abort_done", int'(done), 0);
    @(posedge clk);
    @(posedge clk); #2;
    reset_n = 1;
    repeat (30) @(negedge clk);
    #1;
    chk_i("abort_ready_after", int'(ready), 1);

    // random traffic
    repeat (4000) begin
      @(posedge clk); #2;
      if ($urandom_range(0, 3) == 0) begin
        clr_start = ($urandom_range(0, 5) == 0);
        wr_start  = 1'($urandom_range(0, 1));
        rd_start  = 1'($urandom_range(0, 1));
        clr_mask  = COLS'($urandom_range(0, 65535));
        wr_base   = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(N - 8, N - 1))
                                                : AW'($urandom_range(0, N - 1));
        rd_base   = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(N - 8, N - 1))
                                                : AW'($urandom_range(0, N - 1));
        wr_rows   = rand_rows();
        rd_rows   = rand_rows();
      end else begin
        clr_start = 0; wr_start = 0; rd_start = 0;
      end
    end
    @(posedge clk); #2;
    clr_start = 0; wr_start = 0; rd_start = 0;
    wait_idle();
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
